// File: rtl/rf_scoreboard_pkg.sv
// Shared CPU constants for the register file scoreboard: default sizes,
// the hard-wired zero register index and the write counter width.
package rf_scoreboard_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned CNT_W    = 16;

endpackage

// File: rtl/rf_fwd_mux.sv
// Per-read-port select: zero register, same-cycle write forwarding and the
// busy flag as seen by a reader.
module rf_fwd_mux
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]   rd_adr,
  input  logic [XLEN-1:0] st_dt,
  input  logic            st_busy,
  input  logic            we0,
  input  logic [AW-1:0]   wr_adr0,
  input  logic [XLEN-1:0] wr_dt0,
  input  logic            we1,
  input  logic [AW-1:0]   wr_adr1,
  input  logic [XLEN-1:0] wr_dt1,
  input  logic            rsv_vld,
  input  logic [AW-1:0]   rsv_adr,
  output logic [XLEN-1:0] rd_dt_c,
  output logic            rd_busy_c
);

  logic hit0;
  logic hit1;
  logic rsv_hit;

  // we0/we1 are already qualified by enable, so a disabled port never matches
  always_comb begin
    hit0      = we0 && (wr_adr0 == rd_adr);
    hit1      = we1 && (wr_adr1 == rd_adr);
    rsv_hit   = rsv_vld && (rsv_adr == rd_adr);
    rd_dt_c   = st_dt;
    rd_busy_c = st_busy;
    if (rd_adr == AW'(ZERO_REG)) begin
      rd_dt_c   = '0;
      rd_busy_c = 1'b0;
    end else if (BYPASS != 0) begin
      if (hit1) begin
        rd_dt_c = wr_dt1;
      end else if (hit0) begin
        rd_dt_c = wr_dt0;
      end
      if ((hit0 || hit1) && !rsv_hit) begin
        rd_busy_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Two-read / two-write register file with per-register pending-write
// scoreboard and a saturating committed-write counter.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  RdAdr1,
  input  logic [$clog2(NREG)-1:0]  RdAdr2,
  output logic [XLEN-1:0]          RdDt1,
  output logic [XLEN-1:0]          RdDt2,
  output logic                     RdBusy1,
  output logic                     RdBusy2,
  input  logic                     WrEn0,
  input  logic                     WrEn1,
  input  logic [$clog2(NREG)-1:0]  WrAdr0,
  input  logic [$clog2(NREG)-1:0]  WrAdr1,
  input  logic [XLEN-1:0]          WrDt0,
  input  logic [XLEN-1:0]          WrDt1,
  input  logic                     RsvEn,
  input  logic [$clog2(NREG)-1:0]  RsvAdr,
  input  logic                     Flush,
  output logic [CNT_W-1:0]         WrCnt
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;

  logic             we0;
  logic             we1;
  logic             same_adr;
  logic             rsv_vld;
  logic [1:0]       wr_inc;
  logic [CNT_W:0]   cnt_sum;

  // Qualified enables: enable gates first so a disabled port's address is don't-care
  always_comb begin
    we0      = WrEn0 && (WrAdr0 != AW'(ZERO_REG));
    we1      = WrEn1 && (WrAdr1 != AW'(ZERO_REG));
    same_adr = we0 && we1 && (WrAdr0 == WrAdr1);
    rsv_vld  = RsvEn && !Flush && (RsvAdr != AW'(ZERO_REG));
  end

  // Port 1 is written last so it wins a same-address collision
  always_comb begin
    regs_d = regs_q;
    if (we0) begin
      regs_d[WrAdr0] = WrDt0;
    end
    if (we1) begin
      regs_d[WrAdr1] = WrDt1;
    end
  end

  // Writes clear busy, then flush or a reservation overrides
  always_comb begin
    busy_d = busy_q;
    if (we0) begin
      busy_d[WrAdr0] = 1'b0;
    end
    if (we1) begin
      busy_d[WrAdr1] = 1'b0;
    end
    if (Flush) begin
      busy_d = '0;
    end else if (rsv_vld) begin
      busy_d[RsvAdr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    wr_inc   = 2'({1'b0, we0} + {1'b0, we1}) - 2'(same_adr);
    cnt_sum  = {1'b0, wr_cnt_q} + (CNT_W+1)'(wr_inc);
    wr_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      busy_q   <= '0;
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign WrCnt = wr_cnt_q;

  rf_fwd_mux #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_fwd1 (
    .rd_adr    (RdAdr1),
    .st_dt     (regs_q[RdAdr1]),
    .st_busy   (busy_q[RdAdr1]),
    .we0       (we0),
    .wr_adr0   (WrAdr0),
    .wr_dt0    (WrDt0),
    .we1       (we1),
    .wr_adr1   (WrAdr1),
    .wr_dt1    (WrDt1),
    .rsv_vld   (rsv_vld),
    .rsv_adr   (RsvAdr),
    .rd_dt_c   (RdDt1),
    .rd_busy_c (RdBusy1)
  );

  rf_fwd_mux #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_fwd2 (
    .rd_adr    (RdAdr2),
    .st_dt     (regs_q[RdAdr2]),
    .st_busy   (busy_q[RdAdr2]),
    .we0       (we0),
    .wr_adr0   (WrAdr0),
    .wr_dt0    (WrDt0),
    .we1       (we1),
    .wr_adr1   (WrAdr1),
    .wr_dt1    (WrDt1),
    .rsv_vld   (rsv_vld),
    .rsv_adr   (RsvAdr),
    .rd_dt_c   (RdDt2),
    .rd_busy_c (RdBusy2)
  );

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, at least 4; address width AW = log2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding, 0 disables it.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have ports RdAdr1 and RdAdr2, input, AW bits each, read addresses.
REQ-007 SHALL have ports RdDt1 and RdDt2, output, XLEN bits each, read data.
REQ-008 SHALL have ports RdBusy1 and RdBusy2, output, 1 bit each, pending-write flag of the addressed register.
REQ-009 SHALL have ports WrEn0 and WrEn1, input, 1 bit each, write enables; port 1 is the older pipeline stage and has priority.
REQ-010 SHALL have ports WrAdr0, WrAdr1 (input, AW bits each) and WrDt0, WrDt1 (input, XLEN bits each), the write addresses and write data.
REQ-011 SHALL have ports RsvEn (input, 1 bit) and RsvAdr (input, AW bits), which mark a destination register pending at issue.
REQ-012 SHALL have port Flush, input, 1 bit, which clears all pending flags.
REQ-013 SHALL have port WrCnt, output, 16 bits, a saturating count of committed writes.

Function
REQ-014 SHALL hold register 0 at zero: writes to it are ignored, a reservation of it is ignored, and reads of it return 0 with busy 0.
REQ-015 SHALL commit a write on the rising edge when WrEn is 1 and the write address is not 0.
REQ-016 SHALL, when both write ports target the same nonzero address in one cycle, store WrDt1 only.
REQ-017 SHALL make reads combinational: RdDt equals the stored value, with 0 latency.
REQ-018 SHALL, with BYPASS=1, return write data on a read whose address matches a same-cycle enabled nonzero write; WrDt1 takes precedence over WrDt0.
REQ-019 SHALL, with BYPASS=0, return the pre-edge stored value in that case.
REQ-020 SHALL keep one busy bit per register: RsvEn sets busy[RsvAdr] on the edge; a committed write on either port clears busy[WrAdr].
REQ-021 SHALL, when a reservation and a write target the same address in one cycle, apply the reservation, so busy ends at 1 and the data is still written.
REQ-022 SHALL, on Flush=1, clear every busy bit on the edge; RsvEn in the same cycle is ignored, and writes still commit.
REQ-023 SHALL drive RdBusy from the registered busy bit of the addressed register; with BYPASS=1 it reads 0 when a same-cycle write to that address is in flight and no same-cycle reservation of it exists.
REQ-024 SHALL increment WrCnt by the number of distinct committed writes per cycle (0, 1 or 2; a same-address pair counts 1), saturating at 16'hFFFF.
REQ-025 SHALL NOT let an X on a disabled port's address or data affect state or outputs.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear all registers, all busy bits and WrCnt; RdDt then reads 0 and RdBusy reads 0 unless a same-cycle write is bypassed.
REQ-027 SHALL discard a write, reservation or flush coincident with reset assertion; operation resumes on the first rising edge after rst returns to 1.

Structure
REQ-028 SHALL place the default XLEN, default NREG and the zero-register index constant in the shared CPU package; AW is derived locally.
REQ-029 SHALL contain one sub-module, rf_fwd_mux, instanced per read port, implementing the REQ-018/019/023 select logic.
REQ-030 SHALL implement busy as an NREG-bit vector separate from the data array.

Verification
REQ-031 Write port 0 to x5 with 32'h1234_5678, then read x5 the next cycle -> RdDt1 is 32'h1234_5678.
REQ-032 Same cycle, WrAdr0=WrAdr1=7 with WrDt0=32'hAAAA_AAAA and WrDt1=32'h5555_5555; RdAdr1=7 with BYPASS=1 -> same-cycle RdDt1 is 32'h5555_5555, x7 holds 32'h5555_5555, and WrCnt increments by 1.
REQ-033 RsvEn on x3, then a later write to x3 together with RsvEn on x3 -> RdBusy stays 1 and x3 is updated; a further write with no reservation clears busy.
REQ-034 Reserve x4, x9 and x12, then Flush with RsvEn on x2 -> all busy bits are 0, including x2.
REQ-035 Write x0 with 32'hFFFF_FFFF and RsvEn on x0 -> x0 reads 0, RdBusy is 0 and WrCnt does not increment.
REQ-036 Preload WrCnt to 16'hFFFE by repeated writes, then perform a dual write to distinct addresses -> WrCnt is 16'hFFFF; asserting rst low mid-cycle -> all outputs clear immediately.
